// File: rtl/sysid_verify_seq_pkg.sv
// Shared types and constants for the system-ID verify sequencer.
// Holds the FSM encoding, slave word addresses and default expected words.
package sysid_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b1;
    localparam logic SYSID_ADDR_TS = 1'b0;

    localparam logic [31:0] DEF_EXPECTED_ID = 32'h5041_3C69;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h0000_0000;

    // Counter width able to hold n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sysid_verify_seq_if.sv
// Control-slave read port of the system-ID block.
// The sequencer is master; the sysid slave answers with readdata.
interface sysid_verify_seq_if;
    logic        sysid_address;
    logic        sysid_read;
    logic [31:0] sysid_readdata;

    modport master (
        output sysid_address,
        output sysid_read,
        input  sysid_readdata
    );

    modport slave (
        input  sysid_address,
        input  sysid_read,
        output sysid_readdata
    );
endinterface

// File: rtl/sysid_verify_seq_timer.sv
// Load / decrement down-counter with a zero flag.
// Used for both the read-latency window and the periodic recheck interval.
module sysid_interval_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/sysid_verify_seq.sv
// Boot/periodic sequencer that reads the sysid ID and timestamp words,
// compares them with expected constants, retries on mismatch and reports status.
module sysid_verify_seq
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned RECHECK_CYCLES = 0,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    sysid_verify_seq_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);
    localparam int unsigned RW = cnt_width(RECHECK_CYCLES);
    localparam logic [2:0] LAT = 3'(READ_LATENCY);
    localparam logic [3:0] MAXR = 4'(MAX_RETRY);
    // Loaded with N-1 so the run is accepted N edges after DONE entry.
    localparam logic [RW-1:0] RELOAD =
        RW'((RECHECK_CYCLES == 0) ? 0 : RECHECK_CYCLES - 1);

    state_t state, state_nxt;
    logic auto_pend;
    logic lat_zero, rck_zero;
    logic accept, lat_load, cap_id, cap_ts, retry, finish;
    logic id_ok, ts_ok, recheck_hit, go;

    assign id_ok = (id_value == EXPECTED_ID);
    assign ts_ok = (ts_value == EXPECTED_TS);
    assign recheck_hit = (RECHECK_CYCLES != 0) && (state == S_DONE) && rck_zero;
    assign go = start || auto_pend || recheck_hit;

    sysid_interval_timer #(.WIDTH(3)) u_lat (
        .clock (clock),
        .reset (reset),
        .load  (lat_load),
        .value (LAT),
        .dec   (state == S_RD_ID || state == S_RD_TS),
        .zero  (lat_zero)
    );

    sysid_interval_timer #(.WIDTH(RW)) u_rck (
        .clock (clock),
        .reset (reset),
        .load  (finish),
        .value (RELOAD),
        .dec   (state == S_DONE),
        .zero  (rck_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            auto_pend <= (AUTO_START != 0);
        end else begin
            state     <= state_nxt;
            auto_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt         = state;
        accept            = 1'b0;
        lat_load          = 1'b0;
        cap_id            = 1'b0;
        cap_ts            = 1'b0;
        retry             = 1'b0;
        finish            = 1'b0;
        bus.sysid_read    = 1'b0;
        bus.sysid_address = SYSID_ADDR_TS;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    accept    = 1'b1;
                    lat_load  = 1'b1;
                    state_nxt = S_RD_ID;
                end
            end
            S_RD_ID: begin
                bus.sysid_read    = 1'b1;
                bus.sysid_address = SYSID_ADDR_ID;
                if (lat_zero) begin
                    cap_id    = 1'b1;
                    lat_load  = 1'b1;
                    state_nxt = S_RD_TS;
                end
            end
            S_RD_TS: begin
                bus.sysid_read = 1'b1;
                if (lat_zero) begin
                    cap_ts    = 1'b1;
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if ((id_ok && ts_ok) || retry_count >= MAXR) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    retry     = 1'b1;
                    lat_load  = 1'b1;
                    state_nxt = S_RD_ID;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            retry_count <= '0;
        end else begin
            if (accept) begin
                done        <= 1'b0;
                busy        <= 1'b1;
                retry_count <= '0;
            end
            if (cap_id) id_value <= bus.sysid_readdata;
            if (cap_ts) ts_value <= bus.sysid_readdata;
            if (retry) retry_count <= retry_count + 4'd1;
            if (finish) begin
                pass        <= id_ok && ts_ok;
                id_mismatch <= !id_ok;
                ts_mismatch <= !ts_ok;
                done        <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sysid_verify_seq.sv
// Scoreboard bench for sysid_verify_seq: one default instance and one
// with a 20-cycle recheck interval, each with its own latency-aware slave.
module tb_sysid_verify_seq;
    localparam logic [31:0] GOOD_ID = 32'h5041_3C69;
    localparam int L = 1;

    typedef struct packed {
        logic        pass;
        logic        idm;
        logic        tsm;
        logic [3:0]  retry;
        logic [31:0] idv;
        logic [31:0] tsv;
        logic [15:0] lat;
    } res_t;

    logic clock;
    logic reset, reset1;
    logic start, start1;
    logic [31:0] id_w[2];
    logic [31:0] ts_w[2];

    logic busy_o[2], done_o[2], pass_o[2], idm_o[2], tsm_o[2];
    logic [31:0] idv_o[2], tsv_o[2];
    logic [3:0] rc_o[2];

    int checks = 0;
    int errors = 0;
    res_t exp_q[$];

    sysid_verify_seq_if bus0();
    sysid_verify_seq_if bus1();

    sysid_verify_seq u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bus         (bus0),
        .busy        (busy_o[0]),
        .done        (done_o[0]),
        .pass        (pass_o[0]),
        .id_mismatch (idm_o[0]),
        .ts_mismatch (tsm_o[0]),
        .id_value    (idv_o[0]),
        .ts_value    (tsv_o[0]),
        .retry_count (rc_o[0])
    );

    sysid_verify_seq #(.RECHECK_CYCLES(20)) u_rck (
        .clock       (clock),
        .reset       (reset1),
        .start       (start1),
        .bus         (bus1),
        .busy        (busy_o[1]),
        .done        (done_o[1]),
        .pass        (pass_o[1]),
        .id_mismatch (idm_o[1]),
        .ts_mismatch (tsm_o[1]),
        .id_value    (idv_o[1]),
        .ts_value    (tsv_o[1]),
        .retry_count (rc_o[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave data is only valid once the address has been held L+1 cycles.
    logic la0, lr0, la1, lr1;
    int pc0 = 0, pc1 = 0;
    int run0, run1;
    assign run0 = !bus0.sysid_read ? 0 :
                  (lr0 && la0 == bus0.sysid_address) ? pc0 + 1 : 1;
    assign run1 = !bus1.sysid_read ? 0 :
                  (lr1 && la1 == bus1.sysid_address) ? pc1 + 1 : 1;
    assign bus0.sysid_readdata = (run0 >= L + 1) ?
        (bus0.sysid_address ? id_w[0] : ts_w[0]) : 32'hA5A5_A5A5;
    assign bus1.sysid_readdata = (run1 >= L + 1) ?
        (bus1.sysid_address ? id_w[1] : ts_w[1]) : 32'hA5A5_A5A5;

    always @(posedge clock) begin
        pc0 <= run0;
        la0 <= bus0.sysid_address;
        lr0 <= bus0.sysid_read;
        pc1 <= run1;
        la1 <= bus1.sysid_address;
        lr1 <= bus1.sysid_read;
    end

    function automatic res_t mk(input bit p, input bit im, input bit tm,
                                input int r, input logic [31:0] iv,
                                input logic [31:0] tv, input int lat);
        res_t e;
        e.pass = p;
        e.idm = im;
        e.tsm = tm;
        e.retry = 4'(r);
        e.idv = iv;
        e.tsv = tv;
        e.lat = 16'(lat);
        return e;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("pass=%0b idm=%0b tsm=%0b retry=%0d id=%h ts=%h lat=%0d",
                         r.pass, r.idm, r.tsm, r.retry, r.idv, r.tsv, r.lat);
    endfunction

    // Waits for the run to be accepted (unless already), then for done.
    task automatic observe(input int s, input bit started,
                           output res_t o, output int gap);
        int n;
        gap = 0;
        if (!started) begin
            while (!busy_o[s] && gap < 200) begin
                @(posedge clock);
                #1;
                start = 1'b0;
                gap++;
            end
        end
        n = 1;
        while (!done_o[s] && n < 300) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            n++;
        end
        o.pass = pass_o[s];
        o.idm = idm_o[s];
        o.tsm = tsm_o[s];
        o.retry = rc_o[s];
        o.idv = idv_o[s];
        o.tsv = tsv_o[s];
        o.lat = 16'(n);
    endtask

    task automatic test_reset;
        res_t o, e;
        int g;
        logic [74:0] snap;
        #3;
        snap = {busy_o[0], done_o[0], pass_o[0], idm_o[0], tsm_o[0],
                idv_o[0], tsv_o[0], rc_o[0], bus0.sysid_read, bus0.sysid_address};
        checks++;
        if (snap !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", snap);
        end
        exp_q.push_back(mk(1, 0, 0, 0, GOOD_ID, 0, 6));
        @(negedge clock);
        reset = 1'b0;
        observe(0, 0, o, g);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL auto_start: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_basic;
        res_t o, e;
        int g;
        exp_q.push_back(mk(1, 0, 0, 0, GOOD_ID, 0, 6));
        @(negedge clock);
        start = 1'b1;
        observe(0, 0, o, g);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL basic_pass: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_id_retry;
        res_t o, e;
        int g;
        id_w[0] = 32'hDEAD_BEEF;
        exp_q.push_back(mk(1, 0, 0, 1, GOOD_ID, 0, 11));
        @(negedge clock);
        start = 1'b1;
        fork
            observe(0, 0, o, g);
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clock);
                    #2;
                    if (bus0.sysid_read && !bus0.sysid_address) begin
                        id_w[0] = GOOD_ID;
                        break;
                    end
                end
            end
        join
        id_w[0] = GOOD_ID;
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL id_retry: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_ts_stuck;
        res_t o, e;
        int g;
        ts_w[0] = 32'h1234_5678;
        exp_q.push_back(mk(0, 0, 1, 2, GOOD_ID, 32'h1234_5678, 16));
        @(negedge clock);
        start = 1'b1;
        observe(0, 0, o, g);
        ts_w[0] = 32'h0;
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ts_stuck: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_midrun;
        res_t o, e;
        int g;
        logic [74:0] snap;
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            if (bus0.sysid_read && !bus0.sysid_address) break;
        end
        reset = 1'b1;
        #1;
        snap = {busy_o[0], done_o[0], pass_o[0], idm_o[0], tsm_o[0],
                idv_o[0], tsv_o[0], rc_o[0], bus0.sysid_read, bus0.sysid_address};
        checks++;
        if (snap !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got %h want 0", snap);
        end
        repeat (2) @(negedge clock);
        exp_q.push_back(mk(1, 0, 0, 0, GOOD_ID, 0, 6));
        reset = 1'b0;
        observe(0, 0, o, g);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rerun_after_reset: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_start_busy;
        res_t o, e;
        int g;
        int extra = 0;
        exp_q.push_back(mk(1, 0, 0, 0, GOOD_ID, 0, 6));
        @(negedge clock);
        start = 1'b1;
        fork
            observe(0, 0, o, g);
            begin
                repeat (3) @(negedge clock);
                start = 1'b1;
            end
        join
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL start_busy_run: got %s want %s", fmt(o), fmt(e));
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (busy_o[0]) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL start_busy_ignored: busy cycles %0d want 0", extra);
        end
    endtask

    task automatic test_start_done;
        res_t o, e;
        int g;
        exp_q.push_back(mk(1, 0, 0, 0, GOOD_ID, 0, 6));
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++;
        if ({done_o[0], busy_o[0]} !== 2'b01) begin
            errors++;
            $display("FAIL done_drop: done/busy %b want 01", {done_o[0], busy_o[0]});
        end
        observe(0, 1, o, g);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL start_in_done: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_recheck;
        res_t o, e;
        int g;
        exp_q.push_back(mk(1, 0, 0, 0, GOOD_ID, 0, 6));
        @(negedge clock);
        reset1 = 1'b0;
        observe(1, 0, o, g);
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL recheck_first: got %s want %s", fmt(o), fmt(e));
        end
        id_w[1] = 32'hDEAD_BEEF;
        exp_q.push_back(mk(0, 1, 0, 2, 32'hDEAD_BEEF, 0, 16));
        fork
            observe(1, 0, o, g);
            begin
                while (!busy_o[1]) @(posedge clock);
                #1;
                checks++;
                if (pass_o[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL recheck_pass_hold: pass %b want 1", pass_o[1]);
                end
            end
        join
        checks++;
        if (g !== 20) begin
            errors++;
            $display("FAIL recheck_gap: got %0d want 20", g);
        end
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL recheck_bad_id: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        reset1 = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        id_w[0] = GOOD_ID;
        id_w[1] = GOOD_ID;
        ts_w[0] = 32'h0;
        ts_w[1] = 32'h0;
        test_reset();
        test_basic();
        test_id_retry();
        test_ts_stuck();
        test_reset_midrun();
        test_start_busy();
        test_start_done();
        test_recheck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
